// File: rtl/pc_gen_pkg.sv
// Shared constants, FSM encoding and BTB counter helpers for the fetch-address generator.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pc_gen_pkg;

   localparam int AddrLen = 32;
   localparam logic [AddrLen-1:0] ZERO_WORD = '0;
   localparam logic True  = 1'b1;
   localparam logic False = 1'b0;

   // Two-state fetch FSM: IDLE until the pipeline is first enabled, then RUN forever.
   typedef enum logic {
      PC_IDLE = 1'b0,
      PC_RUN  = 1'b1
   } pc_state_t;

   // Value given to a freshly allocated BTB entry: predicts taken, one miss demotes it.
   localparam logic [1:0] BTB_WEAK_TAKEN = 2'b10;

   // Saturating 2-bit counter step towards "strongly taken".
   function automatic logic [1:0] ctr_inc(input logic [1:0] c);
      return (c == 2'b11) ? c : c + 2'b01;
   endfunction

   // Saturating 2-bit counter step towards "strongly not taken".
   function automatic logic [1:0] ctr_dec(input logic [1:0] c);
      return (c == 2'b00) ? c : c - 2'b01;
   endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch handshake, EX redirect and BTB training signals between pc_gen and the pipeline.
// Latency: none (wiring only).
// Backpressure: IF stalls the generator by holding pc_ready_i low.
interface pc_gen_if
   import pc_gen_pkg::*;
#(
   parameter int ADDR_W = AddrLen
);
   // fetch request towards IF
   logic              pc_valid_o;
   logic              pc_ready_i;
   logic [ADDR_W-1:0] pc_o;
   logic              pred_taken_o;
   logic [ADDR_W-1:0] pred_target_o;
   logic              epoch_o;
   // redirect from EX
   logic              redirect_i;
   logic [ADDR_W-1:0] redirect_pc_i;
   // BTB training from EX
   logic              upd_valid_i;
   logic [ADDR_W-1:0] upd_pc_i;
   logic [ADDR_W-1:0] upd_target_i;
   logic              upd_taken_i;

   // generator side
   modport master (
      output pc_valid_o, pc_o, pred_taken_o, pred_target_o, epoch_o,
      input  pc_ready_i, redirect_i, redirect_pc_i,
      input  upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i
   );

   // pipeline side (IF consumer plus EX redirect/training source)
   modport slave (
      input  pc_valid_o, pc_o, pred_taken_o, pred_target_o, epoch_o,
      output pc_ready_i, redirect_i, redirect_pc_i,
      output upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i
   );

endinterface

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Latency: lookup is combinational; updates are visible the cycle after upd_en.
// Backpressure: none; an update is applied whenever upd_en is high.
module pc_btb
   import pc_gen_pkg::*;
#(
   parameter int ADDR_W     = AddrLen,
   parameter int INST_BYTES = 4,
   parameter int BTB_DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst,
   // lookup port
   input  logic [ADDR_W-1:0] lookup_pc,
   output logic              lookup_hit,
   output logic              lookup_taken,
   output logic [ADDR_W-1:0] lookup_target,
   // training port
   input  logic              upd_en,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              upd_taken
);

   localparam int OFF   = $clog2(INST_BYTES);
   localparam int IDX_W = $clog2(BTB_DEPTH);
   localparam int TAG_W = ADDR_W - OFF - IDX_W;

   logic [BTB_DEPTH-1:0] valid;
   logic [TAG_W-1:0]     tags    [BTB_DEPTH];
   logic [ADDR_W-1:0]    targets [BTB_DEPTH];
   logic [1:0]           ctrs    [BTB_DEPTH];

   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic [IDX_W-1:0] up_idx;
   logic [TAG_W-1:0] up_tag;
   logic             up_hit;

   assign lk_idx = lookup_pc[OFF+IDX_W-1:OFF];
   assign lk_tag = lookup_pc[ADDR_W-1:OFF+IDX_W];
   assign up_idx = upd_pc[OFF+IDX_W-1:OFF];
   assign up_tag = upd_pc[ADDR_W-1:OFF+IDX_W];

   // Instruction-aligned offset bits never reach the index or tag.
   if (OFF > 0) begin : g_offset
      logic unused_offset;
      assign unused_offset = ^{lookup_pc[OFF-1:0], upd_pc[OFF-1:0]};
   end

   // Lookup reads the stored state, so a same-cycle update is seen only next cycle.
   always_comb begin
      lookup_hit    = valid[lk_idx] && (tags[lk_idx] == lk_tag);
      lookup_taken  = lookup_hit && ctrs[lk_idx][1];
      lookup_target = targets[lk_idx];
   end

   assign up_hit = valid[up_idx] && (tags[up_idx] == up_tag);

   // Valid bits are the only BTB state cleared by reset; they gate everything else.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= '0;
      end else if (upd_en && !up_hit && upd_taken) begin
         valid[up_idx] <= True;
      end
   end

   // Tag, target and counter storage: train on a hit, allocate on a taken miss.
   always_ff @(posedge clk) begin
      if (upd_en) begin
         if (up_hit) begin
            if (upd_taken) begin
               ctrs[up_idx]    <= ctr_inc(ctrs[up_idx]);
               targets[up_idx] <= upd_target;
            end else begin
               ctrs[up_idx]    <= ctr_dec(ctrs[up_idx]);
            end
         end else if (upd_taken) begin
            tags[up_idx]    <= up_tag;
            targets[up_idx] <= upd_target;
            ctrs[up_idx]    <= BTB_WEAK_TAKEN;
         end
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: one address per cycle to IF, EX redirects, BTB prediction, epoch bit.
// Latency: next address appears the cycle after a fire or redirect; no bubble on redirect.
// Backpressure: pc_o/epoch_o hold while pc_ready_i is low; a redirect overrides the stall.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int                ADDR_W     = AddrLen,
   parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(ZERO_WORD),
   parameter int                INST_BYTES = 4,
   parameter int                BTB_DEPTH  = 16
) (
   input logic       clk,
   input logic       rst,
   input logic       rdy,
   pc_gen_if.master  bus
);

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INST_BYTES);

   pc_state_t         state;
   logic [ADDR_W-1:0] pc_q;
   logic              valid_q;
   logic              epoch_q;

   logic              pred_hit;
   logic              pred_taken;
   logic [ADDR_W-1:0] pred_target;

   pc_btb #(
      .ADDR_W     (ADDR_W),
      .INST_BYTES (INST_BYTES),
      .BTB_DEPTH  (BTB_DEPTH)
   ) u_btb (
      .clk           (clk),
      .rst           (rst),
      .lookup_pc     (pc_q),
      .lookup_hit    (pred_hit),
      .lookup_taken  (pred_taken),
      .lookup_target (pred_target),
      .upd_en        (rdy && bus.upd_valid_i),
      .upd_pc        (bus.upd_pc_i),
      .upd_target    (bus.upd_target_i),
      .upd_taken     (bus.upd_taken_i)
   );

   // The hit flag alone is not needed here; direction already folds it in.
   logic unused_hit;
   assign unused_hit = pred_hit;

   // Fetch FSM and next-PC mux: redirect beats fire beats hold; rdy low freezes everything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= PC_IDLE;
         pc_q    <= RESET_PC;
         valid_q <= False;
         epoch_q <= False;
      end else if (rdy) begin
         case (state)
            PC_IDLE: begin
               state   <= PC_RUN;
               valid_q <= True;
               if (bus.redirect_i) begin
                  pc_q    <= bus.redirect_pc_i;
                  epoch_q <= ~epoch_q;
               end
            end
            PC_RUN: begin
               if (bus.redirect_i) begin
                  pc_q    <= bus.redirect_pc_i;
                  epoch_q <= ~epoch_q;
               end else if (bus.pc_ready_i) begin
                  pc_q <= pred_taken ? pred_target : pc_q + PC_STEP;
               end
            end
            default: begin
               state   <= PC_IDLE;
               valid_q <= False;
            end
         endcase
      end
   end

   assign bus.pc_valid_o    = valid_q;
   assign bus.pc_o          = pc_q;
   assign bus.epoch_o       = epoch_q;
   assign bus.pred_taken_o  = pred_taken;
   assign bus.pred_target_o = pred_target;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator replacing the single-step PC register at the front of the pipeline. It presents one fetch address per cycle to IF over a valid/ready handshake and holds the address while IF stalls. It takes EX redirects with top priority and predicts taken branches from an internal direct-mapped branch target buffer (BTB) trained by EX. An epoch bit lets downstream stages discard wrong-path instructions.

## Interface
- ADDR_W, 32: address width (matches `AddrLen`)
- RESET_PC, 0: first fetch address after reset
- INST_BYTES, 4: PC increment; power of two
- BTB_DEPTH, 16: BTB entries; power of two, ≥2
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- rdy  in  1  global enable; when low, all state is frozen and all inputs are ignored
- pc_valid_o  out  1  pc_o is a valid fetch request
- pc_ready_i  in  1  IF accepts pc_o this cycle
- pc_o  out  ADDR_W  fetch address
- pred_taken_o  out  1  BTB predicts pc_o as a taken branch (combinational from pc_o)
- pred_target_o  out  ADDR_W  predicted target (combinational; meaningful only when pred_taken_o)
- epoch_o  out  1  toggles on every accepted redirect
- redirect_i  in  1  EX mispredict/jump redirect
- redirect_pc_i  in  ADDR_W  correct next PC
- upd_valid_i  in  1  BTB training strobe for a resolved branch
- upd_pc_i  in  ADDR_W  address of the resolved branch
- upd_target_i  in  ADDR_W  resolved target
- upd_taken_i  in  1  resolved direction

## Operation
- FSM has two states, IDLE and RUN.
- Reset values: state=IDLE, pc_o=RESET_PC, pc_valid_o=0, epoch_o=0, all BTB valid bits=0. Counters, tags and targets are don't-care.
- IDLE: pc_valid_o=0.
  - rdy && !redirect_i → RUN, pc_o keeps RESET_PC.
  - rdy && redirect_i → RUN, pc_o←redirect_pc_i, epoch toggles.
- RUN: pc_valid_o=1. Priority order:
  - Redirect (rdy && redirect_i): pc_o←redirect_pc_i, epoch_o toggles, pc_ready_i ignored.
  - Fire (rdy && pc_ready_i): pc_o←pred_taken_o ? pred_target_o : pc_o+INST_BYTES.
  - Otherwise pc_o holds.
- Addition wraps modulo 2^ADDR_W. redirect_pc_i is loaded verbatim; low bits are not forced to zero.
- BTB lookup:
  - IDX_W=log2(BTB_DEPTH), OFF=log2(INST_BYTES).
  - Index = pc[OFF+IDX_W-1:OFF]; tag = pc[ADDR_W-1:OFF+IDX_W].
  - Entry = {valid, tag, target, 2-bit saturating counter}.
  - hit = valid && tag match; pred_taken_o = hit && ctr[1].
- BTB update (rdy && upd_valid_i), indexed by upd_pc_i:
  - hit && taken: ctr sat-increments (max 3), target←upd_target_i.
  - hit && !taken: ctr sat-decrements (min 0).
  - miss && taken: allocate/overwrite: valid=1, tag, target, ctr=2'b10.
  - miss && !taken: no change.
- An update and a lookup to the same index in the same cycle: the lookup sees the pre-update entry.
- An update and a redirect in the same cycle are independent; both take effect.

## Timing
- Zero-latency handshake. Transfer happens at the rising edge where pc_valid_o && pc_ready_i && rdy. The next address is on pc_o at the following cycle.
- After reset release, the first cycle with rdy=1 moves IDLE→RUN. pc_valid_o=1 with RESET_PC from the next cycle.
- Redirect asserted in cycle N (rdy=1) → pc_o=redirect_pc_i and toggled epoch_o in cycle N+1. There is no bubble.
- While pc_valid_o && !pc_ready_i and no redirect: pc_o, pred_* and epoch_o stay stable. A BTB update to pc_o's index may change pred_* in the cycle after the update.
- rdy low: no state changes; redirect and update pulses are lost. Sources hold them until rdy is high.
- Asynchronous reset mid-operation forces all outputs to their reset values immediately and clears the BTB valid bits.

## Structure
- Constants in `config.v`: `AddrLen`, `ZERO_WORD`, `True`/`False`, plus new `PC_IDLE`/`PC_RUN` state encodings and the `BTB_WEAK_TAKEN` (2'b10) init value.
- One sub-module, `pc_btb`, with ports:
  - combinational lookup port (pc → hit, taken, target);
  - synchronous update port (upd_*);
  - async active-low clear of the valid bits.
- pc_gen holds the FSM, pc_o, epoch_o and the next-PC mux.

## Test plan
- Reset, then rdy=1, pc_ready_i=1 constantly, empty BTB: pc_o=0,4,8,12 on consecutive cycles; epoch_o=0.
- Hold pc_ready_i=0 for 3 cycles at pc_o=0x10: pc_o stays 0x10 with pc_valid_o=1; after release pc_o becomes 0x14.
- Train upd_pc_i=0x20, target 0x100, taken once, then fetch reaches 0x20: pred_taken_o=1, next pc_o=0x100. Two not-taken updates, then fetch 0x20 again: next pc_o=0x24.
- Assert redirect_i with 0x400 while pc_ready_i=0: next cycle pc_o=0x400 and epoch_o toggles. Assert redirect_i and pc_ready_i together: the redirect wins.
- RESET_PC=0xFFFFFFFC, ready: pc_o=0xFFFFFFFC then 0x00000000 (wrap).
- Pull rst low mid-run with BTB trained: outputs return to reset values asynchronously. After release, fetch of 0x20 gives pred_taken_o=0.
